// File: rtl/vdu_console.sv
// Character console: prints to a Wishbone text buffer, handles CR/LF/BS and scrolls.
// Define VDU_CONSOLE_CLEAR_EN to clear the screen after reset and on form feed (0x0C).
module vdu_console #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 25,
  parameter logic [7:0]  BLANK_ATTR = 8'h07
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [7:0]  char_i,
  input  logic [7:0]  attr_i,
  input  logic        char_valid_i,
  output logic        char_ready_o,
  output logic [10:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  output logic [1:0]  wb_sel_o,
  input  logic        wb_ack_i,
  output logic [6:0]  cur_col_o,
  output logic [4:0]  cur_row_o
);

  localparam logic [2:0]  S_IDLE   = 3'd0;
  localparam logic [2:0]  S_PUT    = 3'd1;
  localparam logic [2:0]  S_SCR_RD = 3'd2;
  localparam logic [2:0]  S_SCR_WR = 3'd3;
  localparam logic [2:0]  S_CLR    = 3'd4;

  localparam logic [10:0] L_COLS     = 11'(COLS);
  localparam logic [10:0] L_LAST     = 11'(COLS * ROWS - 1);
  localparam logic [10:0] L_LAST_ROW = 11'((ROWS - 1) * COLS);
  localparam logic [6:0]  L_COL_MAX  = 7'(COLS - 1);
  localparam logic [4:0]  L_ROW_MAX  = 5'(ROWS - 1);
  localparam logic [15:0] L_BLANK    = {BLANK_ATTR, 8'h20};

`ifdef VDU_CONSOLE_CLEAR_EN
  localparam logic [2:0]  S_RST = S_CLR;
`else
  localparam logic [2:0]  S_RST = S_IDLE;
`endif

  logic [2:0]  r_state;
  logic        r_ready;
  logic        r_stb;
  logic        r_we;
  logic [1:0]  r_sel;
  logic [10:0] r_adr;
  logic [15:0] r_dat;
  logic [10:0] r_ptr;
  logic [6:0]  r_col;
  logic [4:0]  r_row;

  logic        w_accept;
  logic [10:0] w_put_adr;

  // r_ready is only ever set in IDLE, so acceptance implies IDLE
  assign w_accept  = char_valid_i & r_ready;
  assign w_put_adr = 11'(r_row) * L_COLS + 11'(r_col);

  // Console FSM: character decode, bus master sequencing and cursor tracking
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= S_RST;
      r_ready <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= 2'b00;
      r_adr   <= 11'd0;
      r_dat   <= 16'd0;
      r_ptr   <= 11'd0;
      r_col   <= 7'd0;
      r_row   <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (char_i)
              8'h0D: r_col <= 7'd0;
              8'h0A: begin
                if (r_row == L_ROW_MAX) begin
                  r_ready <= 1'b0;
                  r_ptr   <= L_COLS;
                  r_state <= S_SCR_RD;
                end else begin
                  r_row <= r_row + 5'd1;
                end
              end
              8'h08: begin
                if (r_col != 7'd0) r_col <= r_col - 7'd1;
              end
`ifdef VDU_CONSOLE_CLEAR_EN
              8'h0C: begin
                r_ready <= 1'b0;
                r_col   <= 7'd0;
                r_row   <= 5'd0;
                r_ptr   <= 11'd0;
                r_state <= S_CLR;
              end
`endif
              default: begin
                r_ready <= 1'b0;
                r_stb   <= 1'b1;
                r_we    <= 1'b1;
                r_sel   <= 2'b11;
                r_adr   <= w_put_adr;
                r_dat   <= {attr_i, char_i};
                r_state <= S_PUT;
              end
            endcase
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_PUT: begin
          if (wb_ack_i) begin
            r_stb <= 1'b0;
            if (r_col == L_COL_MAX) begin
              r_col <= 7'd0;
              if (r_row == L_ROW_MAX) begin
                r_ptr   <= L_COLS;
                r_state <= S_SCR_RD;
              end else begin
                r_row   <= r_row + 5'd1;
                r_ready <= 1'b1;
                r_state <= S_IDLE;
              end
            end else begin
              r_col   <= r_col + 7'd1;
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        // Scroll and clear each idle one cycle between transfers via the !r_stb launch step
        S_SCR_RD: begin
          if (!r_stb) begin
            r_stb <= 1'b1;
            r_we  <= 1'b0;
            r_sel <= 2'b11;
            r_adr <= r_ptr;
          end else if (wb_ack_i) begin
            r_dat   <= wb_dat_i;
            r_stb   <= 1'b0;
            r_state <= S_SCR_WR;
          end
        end
        S_SCR_WR: begin
          if (!r_stb) begin
            r_stb <= 1'b1;
            r_we  <= 1'b1;
            r_adr <= r_ptr - L_COLS;
          end else if (wb_ack_i) begin
            r_stb <= 1'b0;
            if (r_ptr == L_LAST) begin
              r_ptr   <= L_LAST_ROW;
              r_state <= S_CLR;
            end else begin
              r_ptr   <= r_ptr + 11'd1;
              r_state <= S_SCR_RD;
            end
          end
        end
        S_CLR: begin
          if (!r_stb) begin
            r_stb <= 1'b1;
            r_we  <= 1'b1;
            r_sel <= 2'b11;
            r_adr <= r_ptr;
            r_dat <= L_BLANK;
          end else if (wb_ack_i) begin
            r_stb <= 1'b0;
            if (r_ptr == L_LAST) begin
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_ptr <= r_ptr + 11'd1;
            end
          end
        end
        default: begin
          r_stb   <= 1'b0;
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign char_ready_o = r_ready;
  assign wb_adr_o     = r_adr;
  assign wb_dat_o     = r_dat;
  assign wb_we_o      = r_we;
  assign wb_stb_o     = r_stb;
  assign wb_cyc_o     = r_stb;
  assign wb_sel_o     = r_sel;
  assign cur_col_o    = r_col;
  assign cur_row_o    = r_row;

endmodule

// File: tb/tb_vdu_console.sv
// Directed bench for vdu_console: Wishbone slave with programmable wait states and a transfer log.
module tb_vdu_console;

  localparam int LIMIT = 30000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  char_i = 8'h00;
  logic [7:0]  attr_i = 8'h00;
  logic        char_valid_i = 1'b0;
  logic        char_ready_o;
  logic [10:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic [1:0]  wb_sel_o;
  logic        wb_ack_i;
  logic [6:0]  cur_col_o;
  logic [4:0]  cur_row_o;

  vdu_console dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .char_i(char_i), .attr_i(attr_i), .char_valid_i(char_valid_i), .char_ready_o(char_ready_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(wb_ack_i), .cur_col_o(cur_col_o), .cur_row_o(cur_row_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [1:0]  sel;
    logic [10:0] adr;
    logic [15:0] dat;
  } xfer_t;

  xfer_t log_q[$];
  int    ack_dly = 0;
  logic  spur_ack = 1'b0;
  logic  r_ack;
  int    wcnt;
  int    n_checks = 0;
  int    n_pass = 0;
  int    viol = 0;

  // Read data is a fixed function of address so scroll copies are predictable
  assign wb_dat_i = 16'(wb_adr_o) ^ 16'hA500;
  assign wb_ack_i = r_ack | spur_ack;

  // Slave: stb cycles without ack = ack_dly + 1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack <= 1'b0;
      wcnt  <= 0;
    end else if (r_ack) begin
      r_ack <= 1'b0;
      wcnt  <= 0;
    end else if (wb_cyc_o && wb_stb_o) begin
      if (wcnt >= ack_dly) begin
        r_ack <= 1'b1;
        log_q.push_back({wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o});
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  logic        p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [10:0] p_adr = 11'd0;
  logic [15:0] p_dat = 16'd0;
  logic [1:0]  p_sel = 2'b00;

  // Bus protocol monitor: hold-until-ack, drop after ack, cyc tracks stb
  always @(negedge clk) begin
    viol <= viol
      + int'(rst_n && (wb_cyc_o !== wb_stb_o))
      + int'(rst_n && p_stb && !p_ack && (!wb_stb_o || wb_adr_o != p_adr || wb_dat_o != p_dat
                                          || wb_we_o != p_we || wb_sel_o != p_sel))
      + int'(rst_n && p_stb && p_ack && wb_stb_o);
    p_stb <= wb_stb_o; p_ack <= wb_ack_i; p_we <= wb_we_o;
    p_adr <= wb_adr_o; p_dat <= wb_dat_o; p_sel <= wb_sel_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a);
    int k;
    logic rdy;
    @(negedge clk);
    char_i = c; attr_i = a; char_valid_i = 1'b1; k = 0;
    rdy = char_ready_o;
    @(posedge clk);
    while (!rdy && k < LIMIT) begin
      @(negedge clk);
      rdy = char_ready_o;
      @(posedge clk);
      k++;
    end
    if (!rdy) check("send_accept", 32'(k), 32'd0);
    @(negedge clk);
    char_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (char_ready_o !== 1'b1 && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", 32'(k < LIMIT), 32'd1);
  endtask

  function automatic int clear_errs();
    int e = 0;
    if (log_q.size() != 2000) return 9999;
    for (int i = 0; i < 2000; i++)
      if (!log_q[i].we || log_q[i].adr != 11'(i) || log_q[i].dat != 16'h0720) e++;
    return e;
  endfunction

  function automatic int scroll_errs();
    int e = 0;
    xfer_t r, w;
    if (log_q.size() != 3920) return 9999;
    for (int i = 0; i < 1920; i++) begin
      r = log_q[2*i];
      w = log_q[2*i+1];
      if (r.we || r.adr != 11'(80 + i)) e++;
      if (!w.we || w.sel != 2'b11 || w.adr != 11'(i) || w.dat != (16'(80 + i) ^ 16'hA500)) e++;
    end
    for (int j = 0; j < 80; j++)
      if (!log_q[3840+j].we || log_q[3840+j].adr != 11'(1920 + j) || log_q[3840+j].dat != 16'h0720) e++;
    return e;
  endfunction

  initial begin
    int e, waits, guard;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_stb", 32'(wb_stb_o), 32'd0);
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_we", 32'(wb_we_o), 32'd0);
    check("rst_ready", 32'(char_ready_o), 32'd0);
    check("rst_adr", 32'(wb_adr_o), 32'd0);
    check("rst_dat", 32'(wb_dat_o), 32'd0);
    check("rst_sel", 32'(wb_sel_o), 32'd0);
    check("rst_col", 32'(cur_col_o), 32'd0);
    check("rst_row", 32'(cur_row_o), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
`ifdef VDU_CONSOLE_CLEAR_EN
    wait_idle();
    check("boot_clear", 32'(clear_errs()), 32'd0);
`else
    @(negedge clk);
    check("first_ready", 32'(char_ready_o), 32'd1);
`endif

    // 'A' with attr 1E, two wait states
    log_q.delete();
    ack_dly = 1;
    send(8'h41, 8'h1E);
    check("put_latency_stb", 32'(wb_stb_o), 32'd1);
    check("put_busy_ready", 32'(char_ready_o), 32'd0);
    waits = 0;
    while (!wb_ack_i && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    check("put_wait_states", 32'(waits), 32'd2);
    @(negedge clk);
    check("put_stb_drop", 32'(wb_stb_o), 32'd0);
    check("put_ready_back", 32'(char_ready_o), 32'd1);
    check("put_count", 32'(log_q.size()), 32'd1);
    check("put_xfer", 32'(log_q[0]), 32'({1'b1, 2'b11, 11'd0, 16'h1E41}));
    check("put_col", 32'(cur_col_o), 32'd1);
    check("put_row", 32'(cur_row_o), 32'd0);

    // 80 characters fill row 0 and wrap without scrolling; back-to-back sends are held off
    ack_dly = 0;
    send(8'h0D, 8'h00);
    log_q.delete();
    for (int i = 0; i < 80; i++) send(8'h61 + 8'(i % 26), 8'h07);
    wait_idle();
    e = 0;
    for (int i = 0; i < log_q.size(); i++)
      if (!log_q[i].we || log_q[i].adr != 11'(i) || log_q[i].dat != {8'h07, 8'h61 + 8'(i % 26)}) e++;
    check("row_fill_count", 32'(log_q.size()), 32'd80);
    check("row_fill_data", 32'(e), 32'd0);
    check("row_fill_last_adr", 32'(log_q[log_q.size()-1].adr), 32'd79);
    check("row_fill_col", 32'(cur_col_o), 32'd0);
    check("row_fill_row", 32'(cur_row_o), 32'd1);

    // Control codes: no bus traffic, ready stays high
    send(8'h0A, 8'h00);
    send(8'h0A, 8'h00);
    log_q.delete();
    send(8'h08, 8'h00);
    check("bs_ready", 32'(char_ready_o), 32'd1);
    send(8'h0D, 8'h00);
    check("cr_ready", 32'(char_ready_o), 32'd1);
    check("ctl_no_bus", 32'(log_q.size()), 32'd0);
    check("ctl_col", 32'(cur_col_o), 32'd0);
    check("ctl_row", 32'(cur_row_o), 32'd3);
    send(8'h78, 8'h07);
    wait_idle();
    send(8'h08, 8'h00);
    @(negedge clk);
    check("bs_dec_col", 32'(cur_col_o), 32'd0);
    check("bs_dec_row", 32'(cur_row_o), 32'd3);

    // Stray ack while idle changes nothing
    log_q.delete();
    @(negedge clk) spur_ack = 1'b1;
    repeat (4) @(negedge clk);
    spur_ack = 1'b0;
    @(negedge clk);
    check("spur_no_bus", 32'(log_q.size()), 32'd0);
    check("spur_state", 32'({char_ready_o, wb_stb_o, cur_col_o, cur_row_o}), 32'({1'b1, 1'b0, 7'd0, 5'd3}));

    // Form feed
    send(8'h0C, 8'h4F);
    wait_idle();
`ifdef VDU_CONSOLE_CLEAR_EN
    check("ff_clear", 32'(clear_errs()), 32'd0);
    check("ff_home", 32'({cur_col_o, cur_row_o}), 32'd0);
`else
    check("ff_count", 32'(log_q.size()), 32'd1);
    check("ff_xfer", 32'(log_q[0]), 32'({1'b1, 2'b11, 11'd240, 16'h4F0C}));
    check("ff_col", 32'(cur_col_o), 32'd1);
`endif

    // Move to (5,24) and line-feed into a scroll
    send(8'h0D, 8'h00);
    guard = 0;
    while (cur_row_o != 5'd24 && guard < 30) begin
      send(8'h0A, 8'h00);
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), 8'h07);
    wait_idle();
    log_q.delete();
    send(8'h0A, 8'h00);
    wait_idle();
    check("scroll_count", 32'(log_q.size()), 32'd3920);
    check("scroll_seq", 32'(scroll_errs()), 32'd0);
    if (log_q.size() >= 3840) begin
      check("scroll_first_rd", 32'({log_q[0].we, log_q[0].adr}), 32'({1'b0, 11'd80}));
      check("scroll_first_wr", 32'({log_q[1].we, log_q[1].adr}), 32'({1'b1, 11'd0}));
      check("scroll_last_rd", 32'({log_q[3838].we, log_q[3838].adr}), 32'({1'b0, 11'd1999}));
      check("scroll_last_wr", 32'({log_q[3839].we, log_q[3839].adr}), 32'({1'b1, 11'd1919}));
    end
    check("scroll_col", 32'(cur_col_o), 32'd5);
    check("scroll_row", 32'(cur_row_o), 32'd24);

    // Reset in the middle of a scroll
    send(8'h0A, 8'h00);
    repeat (60) @(negedge clk);
    guard = 0;
    while (!wb_stb_o && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_stb", 32'(wb_stb_o), 32'd0);
    check("midrst_cyc", 32'(wb_cyc_o), 32'd0);
    check("midrst_cursor", 32'({cur_col_o, cur_row_o}), 32'd0);
    repeat (2) @(negedge clk);
    log_q.delete();
    rst_n = 1'b1;
`ifdef VDU_CONSOLE_CLEAR_EN
    wait_idle();
    check("midrst_clear", 32'(clear_errs()), 32'd0);
`else
    @(negedge clk);
    check("midrst_ready", 32'(char_ready_o), 32'd1);
    repeat (3) @(negedge clk);
    check("midrst_no_bus", 32'(log_q.size()), 32'd0);
`endif
    check("midrst_home", 32'({cur_col_o, cur_row_o}), 32'd0);

    check("bus_protocol", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
